// File: rtl/receptor_morse.sv
// receptor_morse: receive side of the Morse link.
//   Samples the keyed line, measures mark/space durations in unit ticks and
//   classifies each mark as a dot or a dash. It then assembles characters of
//   1 to 5 elements and flags word gaps and malformed characters.
// Ports:
//   clk      - system clock, all state on the rising edge
//   rst_n    - asynchronous reset, active low
//   tick     - one-clk pulse per Morse time unit
//   linea    - keyed line (1 = mark), asynchronous to clk
//   codigo   - element pattern, bit i = element i (0 dot, 1 dash)
//   longitud - element count (1..5) of codigo
//   valido   - one-clk pulse: codigo/longitud updated
//   espacio  - one-clk pulse: word gap detected
//   error    - one-clk pulse: character discarded
module receptor_morse #(
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned UMBRAL_RAYA     = 2,
    parameter int unsigned UMBRAL_CARACTER = 2,
    parameter int unsigned UMBRAL_PALABRA  = 5,
    parameter int unsigned MAX_MARCA       = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       linea,
    output logic [4:0] codigo,
    output logic [2:0] longitud,
    output logic       valido,
    output logic       espacio,
    output logic       error
);

    localparam logic [CNT_W-1:0] RAYA     = CNT_W'(UMBRAL_RAYA);
    localparam logic [CNT_W-1:0] CARACTER = CNT_W'(UMBRAL_CARACTER);
    localparam logic [CNT_W-1:0] PALABRA  = CNT_W'(UMBRAL_PALABRA);
    localparam logic [CNT_W-1:0] MAXM     = CNT_W'(MAX_MARCA);

    typedef enum logic [2:0] {
        REPOSO,
        MARCA,
        PAUSA,
        HUECO,
        ESPERA_BAJO
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       sr;
    logic [2:0]       count;
    logic             ovf;

    logic             rise, fall;
    logic [CNT_W-1:0] cnt_inc, cnt_next;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    assign cnt_next = tick ? cnt_inc : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            state    <= REPOSO;
            cnt      <= '0;
            sr       <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            codigo   <= '0;
            longitud <= '0;
            valido   <= 1'b0;
            espacio  <= 1'b0;
            error    <= 1'b0;
        end else begin
            s1      <= linea;
            s2      <= s1;
            s3      <= s2;
            valido  <= 1'b0;
            espacio <= 1'b0;
            error   <= 1'b0;
            cnt     <= cnt_next;

            case (state)
                REPOSO: begin
                    if (rise) begin
                        state <= MARCA;
                        cnt   <= '0;
                        sr    <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end

                MARCA: begin
                    if (fall) begin
                        cnt <= '0;
                        if (cnt == '0) begin
                            // Mark shorter than one tick: treat as noise.
                            state <= (count != '0) ? PAUSA : REPOSO;
                        end else begin
                            if (count < 3'd5) begin
                                for (int unsigned i = 0; i < 5; i++) begin
                                    if (3'(i) == count) sr[i] <= (cnt >= RAYA);
                                end
                                count <= count + 3'd1;
                            end else begin
                                ovf <= 1'b1;
                            end
                            state <= PAUSA;
                        end
                    end else if (cnt > MAXM) begin
                        error <= 1'b1;
                        state <= ESPERA_BAJO;
                        cnt   <= '0;
                    end
                end

                PAUSA: begin
                    if (tick && cnt_inc == CARACTER) begin
                        if (ovf) begin
                            error <= 1'b1;
                        end else begin
                            valido   <= 1'b1;
                            codigo   <= sr;
                            longitud <= count;
                        end
                        // A mark starting on the closing tick begins a new character.
                        if (rise) begin
                            state <= MARCA;
                            cnt   <= '0;
                            sr    <= '0;
                            count <= '0;
                            ovf   <= 1'b0;
                        end else begin
                            state <= HUECO;
                        end
                    end else if (rise) begin
                        state <= MARCA;
                        cnt   <= '0;
                    end
                end

                HUECO: begin
                    if (rise) begin
                        state <= MARCA;
                        cnt   <= '0;
                        sr    <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end else if (tick && cnt_inc == PALABRA) begin
                        espacio <= 1'b1;
                        state   <= REPOSO;
                        cnt     <= '0;
                    end
                end

                ESPERA_BAJO: begin
                    if (!s2) begin
                        state <= REPOSO;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= REPOSO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receptor_morse.sv
// tb_receptor_morse: directed bench for receptor_morse with a pulse scoreboard.
module tb_receptor_morse;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick;
    logic       linea = 1'b0;
    logic [4:0] codigo;
    logic [2:0] longitud;
    logic       valido, espacio, error;

    logic [1:0] phase = 2'd0;

    int unsigned tests = 0;
    int unsigned fails = 0;

    typedef struct {
        int unsigned kind;   // 1 valido, 2 espacio, 3 error
        logic [4:0]  cod;
        logic [2:0]  len;
    } ev_t;

    ev_t        expq[$];
    logic [4:0] last_cod = '0;
    logic [2:0] last_len = '0;
    logic       prev_pulse = 1'b0;

    receptor_morse dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .linea    (linea),
        .codigo   (codigo),
        .longitud (longitud),
        .valido   (valido),
        .espacio  (espacio),
        .error    (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) phase <= phase + 2'd1;
    assign tick = (phase == 2'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int unsigned kind, input logic [4:0] cod, input logic [2:0] len);
        ev_t e;
        e.kind = kind;
        e.cod  = cod;
        e.len  = len;
        expq.push_back(e);
    endtask

    task automatic align();
        @(negedge clk);
        while (phase != 2'd1) @(negedge clk);
    endtask

    // Mark for 'hi' units then space for 'lo' units, phase-aligned.
    task automatic send(input int unsigned hi, input int unsigned lo);
        linea = 1'b1;
        repeat (4 * hi) @(negedge clk);
        linea = 1'b0;
        repeat (4 * lo) @(negedge clk);
    endtask

    // Scoreboard: every output pulse is matched against the next expected event.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pulse = 1'b0;
        end else if (valido || espacio || error) begin
            ev_t e;
            int unsigned k;
            k = valido ? 1 : (espacio ? 2 : 3);
            check("onehot", 32'(valido) + 32'(espacio) + 32'(error), 32'd1);
            check("pulse_width", 32'(prev_pulse), 32'd0);
            check("unexpected_pulse", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("kind", k, e.kind);
                if (k == 1) begin
                    last_cod = e.cod;
                    last_len = e.len;
                end
                check("codigo", 32'(codigo), 32'(last_cod));
                check("longitud", 32'(longitud), 32'(last_len));
            end
            prev_pulse = 1'b1;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_codigo", 32'(codigo), 32'd0);
        check("rst_longitud", 32'(longitud), 32'd0);
        check("rst_pulses", {29'd0, valido, espacio, error}, 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // 'A' = dot dash
        push(1, 5'b00010, 3'd2);
        push(2, 5'b00010, 3'd2);
        align();
        send(1, 1);
        send(3, 8);
        check("A_drained", expq.size(), 32'd0);

        // 'N' = dash dot, 1-clk glitch inside the closing space
        push(1, 5'b00001, 3'd2);
        push(2, 5'b00001, 3'd2);
        align();
        send(3, 1);
        linea = 1'b1;
        repeat (4) @(negedge clk);
        linea = 1'b0;
        repeat (4) @(negedge clk);
        linea = 1'b1;
        @(negedge clk);
        linea = 1'b0;
        repeat (40) @(negedge clk);
        check("N_drained", expq.size(), 32'd0);

        // '0' = five dashes, then a word gap
        push(1, 5'b11111, 3'd5);
        push(2, 5'b11111, 3'd5);
        align();
        repeat (4) send(3, 1);
        send(3, 7);
        repeat (8) @(negedge clk);
        check("zero_drained", expq.size(), 32'd0);

        // six dots: overflow, codigo keeps 11111
        push(3, 5'b11111, 3'd5);
        push(2, 5'b11111, 3'd5);
        align();
        repeat (5) send(1, 1);
        send(1, 8);
        check("six_drained", expq.size(), 32'd0);
        check("six_hold_codigo", 32'(codigo), 32'h1f);
        check("six_hold_len", 32'(longitud), 32'd5);

        // reset in the middle of the first dash of 'K'
        align();
        linea = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_codigo", 32'(codigo), 32'd0);
        check("midrst_longitud", 32'(longitud), 32'd0);
        check("midrst_pulses", {29'd0, valido, espacio, error}, 32'd0);
        last_cod = '0;
        last_len = '0;
        linea = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        check("postrst_quiet", expq.size(), 32'd0);

        // 'E' after reset
        push(1, 5'b00000, 3'd1);
        push(2, 5'b00000, 3'd1);
        align();
        send(1, 8);
        check("E_drained", expq.size(), 32'd0);

        // stuck key for 10 units, then a clean dot
        push(3, 5'b00000, 3'd1);
        align();
        send(10, 2);
        check("stuck_drained", expq.size(), 32'd0);
        push(1, 5'b00000, 3'd1);
        push(2, 5'b00000, 3'd1);
        align();
        send(1, 8);
        repeat (8) @(negedge clk);
        check("final_drained", expq.size(), 32'd0);
        check("final_longitud", 32'(longitud), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
